// File: rtl/mux_rr_sched.sv
`default_nettype none
// ============================================================================
// Module  : mux_rr_sched
// Brief   : Round-robin scheduler sharing one N:1 data mux behind a single
//           registered output stage with valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
module mux_rr_sched #(
  parameter int WD     = 8,
  parameter int bitsel = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2**bitsel-1:0]   req,
  input  logic [WD-1:0]          in [2**bitsel],
  output logic [2**bitsel-1:0]   ack,
  output logic [WD-1:0]          out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [bitsel-1:0]      sel
);

  localparam int N = 2**bitsel;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [bitsel-1:0] r_ptr;
  logic [WD-1:0]     r_out;
  logic [bitsel-1:0] r_sel;
  logic [bitsel-1:0] w_idx;
  logic [bitsel-1:0] w_winner;
  logic              w_found;
  logic              w_load;

  // Search starts at the priority pointer and wraps naturally in bitsel bits.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = r_ptr + bitsel'(k);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // rst_n gates load so ack stays low throughout reset.
  assign w_load = rst_n && w_found && ((r_state == S_IDLE) || out_ready);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_load) w_state_nxt = S_BUSY;
      S_BUSY:  if (out_ready) w_state_nxt = w_load ? S_BUSY : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ack = '0;
    if (w_load) ack[w_winner] = 1'b1;
    out_valid = (r_state == S_BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_out <= '0;
      r_sel <= '0;
    end else if (w_load) begin
      r_ptr <= w_winner + 1'b1;
      r_out <= in[w_winner];
      r_sel <= w_winner;
    end
  end

  assign out = r_out;
  assign sel = r_sel;

endmodule
`default_nettype wire
